// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: default sizing, a width-generic Gray-to-binary
// decode and a population count, reused by the encoder/decoder benches.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_ERRW  = 8;
  localparam int MAX_WIDTH     = 64;

  // Decodes the low `width` bits of g; callers zero-extend narrower codes.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g,
                                                    input int width);
    logic [MAX_WIDTH-1:0] b;
    logic                 acc;
    b   = '0;
    acc = 1'b0;
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      if (i < width) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_bin_dec_if.sv
// Input and output valid/ready streams of the Gray decoder, plus its error count.
interface gray_bin_dec_if
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ERRW  = DEFAULT_ERRW
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] gray_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] bin_out;
  logic             step_err;
  logic [ERRW-1:0]  err_cnt;

  modport master (
    output in_valid, gray_in, out_ready,
    input  in_ready, out_valid, bin_out, step_err, err_cnt
  );

  modport slave (
    input  in_valid, gray_in, out_ready,
    output in_ready, out_valid, bin_out, step_err, err_cnt
  );

endinterface

// File: rtl/gray_bin_dec_gray2bin_comb.sv
// Pure combinational WIDTH-bit Gray-to-binary decode.
module gray2bin_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(MAX_WIDTH'(gray), WIDTH));

endmodule

// File: rtl/gray_bin_dec.sv
// Two-stage Gray-to-binary decoder on valid/ready streams; flags and counts
// accepted codes that differ from the previous accepted code in 2+ bits.
module gray_bin_dec
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ERRW  = DEFAULT_ERRW
) (
  input logic           clk,
  input logic           rst_n,
  gray_bin_dec_if.slave bus
);

  localparam logic [ERRW-1:0] ERR_MAX = '1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_gray_q,  s1_gray_d;
  logic             s1_err_q,   s1_err_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_bin_q,   s2_bin_d;
  logic             s2_err_q,   s2_err_d;
  logic             prev_valid_q, prev_valid_d;
  logic [WIDTH-1:0] prev_gray_q,  prev_gray_d;
  logic [ERRW-1:0]  err_cnt_q,    err_cnt_d;

  logic             adv1, adv2, accept, out_xfer, step_bad;
  logic [WIDTH-1:0] s1_bin;

  // Each stage advances when it is empty or the stage after it is draining,
  // so a full pipe with out_ready=1 moves and accepts in the same cycle.
  assign adv2     = !s2_valid_q || bus.out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign accept   = bus.in_valid && adv1;
  assign out_xfer = s2_valid_q && bus.out_ready;
  assign step_bad = prev_valid_q &&
                    (popcount(MAX_WIDTH'(bus.gray_in ^ prev_gray_q)) >= 2);

  gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
    .gray (s1_gray_q),
    .bin  (s1_bin)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves it unassigned
    // and no latch is inferred.
    s1_valid_d   = s1_valid_q;
    s1_gray_d    = s1_gray_q;
    s1_err_d     = s1_err_q;
    s2_valid_d   = s2_valid_q;
    s2_bin_d     = s2_bin_q;
    s2_err_d     = s2_err_q;
    prev_valid_d = prev_valid_q;
    prev_gray_d  = prev_gray_q;
    err_cnt_d    = err_cnt_q;

    if (adv1) begin
      s1_valid_d = bus.in_valid;
    end
    if (accept) begin
      s1_gray_d    = bus.gray_in;
      s1_err_d     = step_bad;
      prev_gray_d  = bus.gray_in;
      prev_valid_d = 1'b1;
    end

    if (adv2) begin
      s2_valid_d = s1_valid_q;
      s2_bin_d   = s1_bin;
      s2_err_d   = s1_err_q;
    end

    // Counted on output transfer, so a held output is never double-counted.
    if (out_xfer && s2_err_q && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_gray_q    <= '0;
      s1_err_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_bin_q     <= '0;
      s2_err_q     <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_gray_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values and the two
      // stages shift together rather than falling through in one cycle.
      s1_valid_q   <= s1_valid_d;
      s1_gray_q    <= s1_gray_d;
      s1_err_q     <= s1_err_d;
      s2_valid_q   <= s2_valid_d;
      s2_bin_q     <= s2_bin_d;
      s2_err_q     <= s2_err_d;
      prev_valid_q <= prev_valid_d;
      prev_gray_q  <= prev_gray_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid_q;
  assign bus.bin_out   = s2_bin_q;
  assign bus.step_err  = s2_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_bin_dec.sv
// Self-checking bench for gray_bin_dec: directed scenarios plus random traffic,
// all compared every cycle against a transaction-level model.
module tb_gray_bin_dec;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, out_ready;
  logic [W-1:0] gray_in;

  gray_bin_dec_if #(.WIDTH(W), .ERRW(8)) bus ();
  gray_bin_dec_if #(.WIDTH(W), .ERRW(2)) bus_s ();

  assign bus.in_valid    = in_valid;
  assign bus.gray_in     = gray_in;
  assign bus.out_ready   = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.gray_in   = gray_in;
  assign bus_s.out_ready = out_ready;

  gray_bin_dec #(.WIDTH(W), .ERRW(8)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
  gray_bin_dec #(.WIDTH(W), .ERRW(2)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: the binary b whose Gray encoding b^(b>>1) equals g.
  function automatic int model_bin(input int g);
    for (int b = 0; b < (1 << W); b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  typedef struct {
    int bin;
    bit err;
    int acc;
  } item_t;

  item_t q[$];
  int    obs_q[$];
  int    ec = 0;
  int    last_pop = 0;
  bit    m_prev_valid = 0;
  int    m_prev_gray = 0;
  int    m_cnt = 0;
  int    m_cnt_s = 0;

  always @(posedge clk) ec = ec + 1;

  // Model state changes on the edge following each negedge evaluation.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      obs_q.delete();
      m_prev_valid = 0;
      m_cnt        = 0;
      m_cnt_s      = 0;
      last_pop     = 0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_bin_out",   bus.bin_out, 0);
      check("rst_step_err",  bus.step_err, 0);
      check("rst_err_cnt",   bus.err_cnt, 0);
      check("rst_err_cnt_s", bus_s.err_cnt, 0);
    end else begin
      bit vis, exp_ready;
      vis = 0;
      if (q.size() > 0) begin
        int t;
        t = (q[0].acc + 1 > last_pop) ? q[0].acc + 1 : last_pop;
        vis = (ec >= t);
      end
      exp_ready = (q.size() < 2) || out_ready;
      check("out_valid",   bus.out_valid, vis);
      check("out_valid_s", bus_s.out_valid, vis);
      check("in_ready",    bus.in_ready, exp_ready);
      check("err_cnt",     bus.err_cnt, m_cnt);
      check("err_cnt_s",   bus_s.err_cnt, m_cnt_s);
      if (vis) begin
        check("bin_out",   bus.bin_out, q[0].bin);
        check("step_err",  bus.step_err, q[0].err);
        check("bin_out_s", bus_s.bin_out, q[0].bin);
      end
      if (vis && out_ready) begin
        item_t it;
        it = q.pop_front();
        obs_q.push_back(int'(bus.bin_out));
        if (it.err) begin
          if (m_cnt < 255) m_cnt++;
          if (m_cnt_s < 3) m_cnt_s++;
        end
        last_pop = ec + 1;
      end
      if (in_valid && exp_ready) begin
        item_t it;
        it.bin = model_bin(int'(gray_in));
        it.err = m_prev_valid && ($countones(int'(gray_in) ^ m_prev_gray) >= 2);
        it.acc = ec + 1;
        q.push_back(it);
        m_prev_gray  = int'(gray_in);
        m_prev_valid = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] g);
    bit acc;
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    gray_in  = g;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      guard++;
    end while (!acc && guard < 64);
    check("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int exp_bin, input bit exp_err, input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.out_valid && guard < 32) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_valid"}, bus.out_valid, 1);
    check({name, "_bin"},   bus.bin_out, exp_bin);
    check({name, "_err"},   bus.step_err, exp_err);
    step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) step();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (6) step();
  endtask

  logic [W-1:0] bp_codes [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k;
    int guard;
    logic [W-1:0] last;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    gray_in   = '0;
    out_ready = 1'b1;
    repeat (3) step();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready",  bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    step();

    // Sweep binary 0..15 as Gray codes, back to back.
    for (int b = 0; b < 16; b++) send(W'(b ^ (b >> 1)));
    drain();
    check("sweep_count", obs_q.size(), 16);
    for (int b = 0; b < 16 && b < obs_q.size(); b++) check("sweep_val", obs_q[b], b);
    check("sweep_err_cnt", bus.err_cnt, 0);

    // 1000 -> 0000 wraps with a single bit change.
    send(4'b0000);
    wait_out(0, 0, "wrap");

    send(4'b0110);
    wait_out(4, 1, "spot_0110");
    send(4'b1101);
    wait_out(9, 1, "spot_1101");

    do_reset();
    send(4'b0000);
    wait_out(0, 0, "ill_first");
    send(4'b0011);
    wait_out(2, 1, "ill_step");
    check("ill_err_cnt", bus.err_cnt, 1);
    send(4'b0001);
    wait_out(1, 0, "ill_recover");

    // Backpressure: two codes absorbed, then in_ready drops.
    do_reset();
    bp_codes = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    out_ready = 1'b0;
    k = 0;
    in_valid = 1'b1;
    gray_in  = bp_codes[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      if (acc) begin
        k++;
        if (k < 4) gray_in = bp_codes[k];
        else in_valid = 1'b0;
      end
    end
    check("bp_absorbed", k, 2);
    @(negedge clk);
    check("bp_in_ready_low", bus.in_ready, 0);
    step();
    out_ready = 1'b1;
    guard = 0;
    while (k < 4 && guard < 32) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      guard++;
      if (acc) begin
        k++;
        if (k < 4) gray_in = bp_codes[k];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("bp_all_accepted", k, 4);
    drain();
    check("bp_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) check("bp_order", obs_q[i], i + 1);

    // Five illegal steps: the 2-bit counter stops at 3.
    do_reset();
    send(4'b0000);
    for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 4'b1111 : 4'b0000);
    drain();
    check("sat_err_cnt_8", bus.err_cnt, 5);
    check("sat_err_cnt_2", bus_s.err_cnt, 3);

    // Random traffic mixing single-bit steps and arbitrary codes.
    last = '0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) gray_in = last ^ W'(1 << $urandom_range(0, W - 1));
      else gray_in = W'($urandom);
      last = gray_in;
      step();
    end
    in_valid = 1'b0;
    drain();

    // Reset with two codes in flight.
    out_ready = 1'b0;
    send(4'b1111);
    send(4'b0000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_err_cnt",   bus.err_cnt, 0);
    check("midrst_err_cnt_s", bus_s.err_cnt, 0);
    repeat (2) step();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    send(4'b0101);
    wait_out(6, 0, "midrst_first");
    send(4'b1010);
    wait_out(12, 1, "midrst_second");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_bin_dec.md
Name: gray_bin_dec

Overview:
Sequential Gray-to-binary decoder; the receive-side counterpart of the binary-to-Gray encoder. It accepts Gray codes on a valid/ready stream and returns the binary value two cycles later on a second valid/ready stream. It also checks that each accepted code is a legal Gray step from the previous one, and counts the violations. It sits after Gray-coded counters and pointers, before any binary arithmetic.

Parameters:
WIDTH, 4, bit width of gray_in and bin_out (>=2)
ERRW, 8, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  gray_in holds a code
in_ready  output  1  block accepts gray_in this cycle
gray_in  input  WIDTH  Gray code
out_valid  output  1  bin_out/step_err valid
out_ready  input  1  downstream accepts output
bin_out  output  WIDTH  decoded binary
step_err  output  1  this output's code was an illegal step
err_cnt  output  ERRW  saturating count of illegal steps

Behaviour:
- Reset (async assert, sync release): all outputs 0, including out_valid=0 and err_cnt=0. Pipeline valid bits, prev_valid and prev_gray clear to 0. in_ready=1 once rst_n=1.
- Handshakes:
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
  - Once raised, out_valid stays high and bin_out/step_err stay stable until the transfer.
- Pipeline has two stages:
  - S1 registers gray_in and computes the step check.
  - S2 registers the binary value and step_err.
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 (combinational from out_ready and internal state; no path from in_valid).
- Latency: an accepted code appears on bin_out exactly 2 cycles after acceptance when out_ready=1. Throughput is 1 per cycle.
- Buffering: at most 2 codes in flight. Under out_ready=0 the block absorbs 2 codes, then in_ready=0. Nothing is dropped or duplicated, and order is preserved.
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i] for i from WIDTH-2 down to 0.
- Step check, evaluated on each accepted code against prev_gray:
  - d = popcount(gray_in ^ prev_gray).
  - err = prev_valid && (d >= 2).
  - d = 0 (hold) is legal; d = 1 is legal.
  - The first code after reset never errors (prev_valid=0).
  - On every acceptance, prev_gray is updated to gray_in and prev_valid is set to 1, whether or not the step was an error.
- Wrap-around: the step from all-ones binary back to 0 (Gray 1000 to 0000 for WIDTH=4) has d=1 and is legal.
- err_cnt increments when an output with step_err=1 transfers. It saturates at 2^ERRW-1 and never wraps.
- Simultaneous events:
  - With S2 full, out_ready=1 and S1 full, S2 loads from S1 in the same cycle as the output transfer.
  - S1 may also accept a new code in that same cycle; no bubble is inserted.
- Reset mid-operation: in-flight codes are discarded, out_valid drops immediately, err_cnt and prev_valid clear.

Decomposition:
- Shared package gray_pkg contains:
  - default WIDTH
  - function gray2bin(width-generic loop)
  - function popcount
  - These are shared with the bin_gray encoder bench as the reference model.
- One natural sub-module, gray2bin_comb (pure combinational WIDTH-bit decode), instantiated in S1 to S2.
- The pipeline and checker stay in the top module.

Test Plan:
- Sweep: feed Gray codes for binary 0..15 in order with out_ready=1. Expect bin_out = 0..15, step_err=0 throughout, err_cnt=0, each output 2 cycles after acceptance.
- Spot values: gray_in=0110 -> bin_out=0100; gray_in=1101 -> bin_out=1001.
- Illegal step: feed 0000 then 0011. Expect second output bin_out=0010, step_err=1, err_cnt=1. Then feeding 0001 gives d=1, so step_err=0.
- Backpressure: in_valid=1 with codes 0001, 0011, 0010, 0110 and out_ready=0 for 4 cycles. Expect in_ready=0 after 2 acceptances. On release, outputs are 1, 2, 3, 4 in order with no loss.
- Wrap-around and saturation:
  - Feed 1000 then 0000. Expect step_err=0.
  - With ERRW=2, feed 5 illegal steps. Expect err_cnt stops at 3.
- Reset mid-stream: assert rst_n=0 with 2 codes in flight. Expect out_valid=0 and err_cnt=0 immediately. The first code after release gives step_err=0 regardless of its value.
